axi_stream_packet_arbiter: RTL and testbench

//  Shares one AXI-Stream master port among NUM_INPUTS AXI-Stream slave ports.

---
 rtl/axi_stream_pkg.sv | 15 +
 rtl/axi_stream_skid_buffer.sv | 76 +++++++
 rtl/axi_stream_packet_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_stream_packet_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream blocks.
//   arb_state_t  : packet arbiter FSM state (IDLE waits for requests, BUSY forwards one packet)
//   index_width  : width needed to index n items, never less than 1
package axi_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry registered AXI-Stream slice.
// Both directions are registered: s_ready comes straight from a flop, so there is
// no combinational path from m_ready back to the source. Latency is one cycle and a
// continuously high m_ready gives one beat per cycle.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   s_valid/s_ready + s_* payload    upstream beat (data, strb, keep, last, user, id)
//   m_valid/m_ready + m_* payload    downstream beat, payload held while stalled
module axi_stream_skid_buffer #(
    parameter int byte_width = 4,
    parameter int user_width = 1,
    parameter int id_width   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*byte_width-1:0] s_data,
    input  logic [byte_width-1:0]   s_strb,
    input  logic [byte_width-1:0]   s_keep,
    input  logic                    s_last,
    input  logic [user_width-1:0]   s_user,
    input  logic [id_width-1:0]     s_id,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*byte_width-1:0] m_data,
    output logic [byte_width-1:0]   m_strb,
    output logic [byte_width-1:0]   m_keep,
    output logic                    m_last,
    output logic [user_width-1:0]   m_user,
    output logic [id_width-1:0]     m_id
);

    localparam int PW = 8*byte_width + 2*byte_width + 1 + user_width + id_width;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] out_pl;
    logic [PW-1:0] skid_pl;
    logic          out_valid;
    logic          skid_valid;

    assign in_pl   = {s_data, s_strb, s_keep, s_last, s_user, s_id};
    // Accept whenever the spare entry is free; a beat that arrives while the output
    // is stalled parks there, which is what lets s_ready be a plain register.
    assign s_ready = !skid_valid;
    assign m_valid = out_valid;
    assign {m_data, m_strb, m_keep, m_last, m_user, m_id} = out_pl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pl     <= '0;
            skid_pl    <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (m_ready || !out_valid) begin
                // Output slot frees up: the parked beat is older, so it goes first.
                // While it is parked s_ready is low, so no new beat can arrive.
                if (skid_valid) begin
                    out_pl     <= skid_pl;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (s_valid) begin
                    out_pl    <= in_pl;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (s_valid && !skid_valid) begin
                skid_pl    <= in_pl;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Round-robin, packet-granular AXI-Stream arbiter with a registered output.
// A grant is taken in IDLE and held in BUSY until the granted input's tlast beat
// transfers; one IDLE cycle separates consecutive packets. m_tid carries the index
// of the input that sourced each beat.
// Handshake: a beat moves on a port in any cycle where its valid and ready are both
// high; valid never waits for ready, and once high it and the payload hold until
// the transfer.
// Ports:
//   clk, reset                                 clock, asynchronous active-high reset
//   s_tvalid/s_tready/s_tlast                  per-input handshake and end of packet
//   s_tdata/s_tstrb/s_tkeep/s_tuser            concatenated payloads, input i at slice i
//   m_tvalid/m_tready                          shared output handshake
//   m_tdata/m_tstrb/m_tkeep/m_tlast/m_tuser    muxed, registered payload
//   m_tid                                      source input index of the beat
module axi_stream_packet_arbiter
    import axi_stream_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int byte_width = 4,
    parameter  int user_width = 1,
    localparam int SEL_WIDTH  = index_width(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_INPUTS-1:0]              s_tvalid,
    output logic [NUM_INPUTS-1:0]              s_tready,
    input  logic [NUM_INPUTS*8*byte_width-1:0] s_tdata,
    input  logic [NUM_INPUTS*byte_width-1:0]   s_tstrb,
    input  logic [NUM_INPUTS*byte_width-1:0]   s_tkeep,
    input  logic [NUM_INPUTS-1:0]              s_tlast,
    input  logic [NUM_INPUTS*user_width-1:0]   s_tuser,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [8*byte_width-1:0]            m_tdata,
    output logic [byte_width-1:0]              m_tstrb,
    output logic [byte_width-1:0]              m_tkeep,
    output logic                               m_tlast,
    output logic [user_width-1:0]              m_tuser,
    output logic [SEL_WIDTH-1:0]               m_tid
);

    localparam int DW = 8*byte_width;

    arb_state_t           state, state_nxt;
    logic [SEL_WIDTH-1:0] grant, grant_nxt;
    logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic [SEL_WIDTH-1:0] cand_idx;
    logic                 pick_found;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DW-1:0]         sel_data;
    logic [byte_width-1:0] sel_strb;
    logic [byte_width-1:0] sel_keep;
    logic [user_width-1:0] sel_user;

    logic skid_ready;
    logic skid_valid;

    // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... wrapping, first requester wins.
    // rr_ptr is the last input served, so it lands at the back of the order.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand_idx = SEL_WIDTH'((32'(rr_ptr) + 32'(k)) % 32'(NUM_INPUTS));
            if (!pick_found && s_tvalid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Payload and handshake of the granted input.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SEL_WIDTH'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DW +: DW];
                sel_strb  = s_tstrb[i*byte_width +: byte_width];
                sel_keep  = s_tkeep[i*byte_width +: byte_width];
                sel_user  = s_tuser[i*user_width +: user_width];
            end
        end
    end

    // Only the granted input ever sees ready, and only while BUSY.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            s_tready[i] = (state == BUSY) && (grant == SEL_WIDTH'(i)) && skid_ready;
        end
    end

    assign skid_valid = (state == BUSY) && sel_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= SEL_WIDTH'(NUM_INPUTS - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Grant survives source gaps; only the tlast transfer releases it.
                if (sel_valid && skid_ready && sel_last) begin
                    rr_ptr_nxt = grant;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    axi_stream_skid_buffer #(
        .byte_width (byte_width),
        .user_width (user_width),
        .id_width   (SEL_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_valid (skid_valid),
        .s_ready (skid_ready),
        .s_data  (sel_data),
        .s_strb  (sel_strb),
        .s_keep  (sel_keep),
        .s_last  (sel_last),
        .s_user  (sel_user),
        .s_id    (grant),
        .m_valid (m_tvalid),
        .m_ready (m_tready),
        .m_data  (m_tdata),
        .m_strb  (m_tstrb),
        .m_keep  (m_tkeep),
        .m_last  (m_tlast),
        .m_user  (m_tuser),
        .m_id    (m_tid)
    );

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
`timescale 1ns/1ps
module tb_axi_stream_packet_arbiter;

  localparam int N      = 4;
  localparam int BW     = 4;
  localparam int UW     = 1;
  localparam int SW     = 2;
  localparam int DW     = 8*BW;
  localparam int BEAT_W = DW + BW + BW + 1 + UW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] strb;
    logic [BW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    logic [3:0]    gap;   // idle cycles before this beat is offered
  } src_beat_t;

  // One scenario: every input in mask offers npk packets of len beats at once;
  // ord lists the expected packet source order, first packet in the top nibble.
  typedef struct {
    int          mask;
    int          len;
    int          npk;
    int          n_ord;
    logic [47:0] ord;
  } row_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*BW-1:0] s_tstrb, s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [BW-1:0]   m_tstrb, m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic [SW-1:0]   m_tid;

  axi_stream_packet_arbiter #(.NUM_INPUTS(N), .byte_width(BW), .user_width(UW)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid)
  );

  // ---------------- bench state ----------------
  src_beat_t         src_q[N][$];
  logic [BEAT_W-1:0] exp_q[N][$];
  int                pkt_tid_q[$];
  int                out_cyc_q[$];
  bit                out_last_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_pct = 100;
  int fire_cnt[N];
  bit fired[N];
  bit presenting[N];
  int gap_used[N];
  int onehot_err = 0;
  int stab_err = 0;
  int early_err = 0;
  int beats_seen = 0;
  bit t3_watch = 0;
  bit t3_done = 0;
  bit in_pkt = 0;
  int cur_tid = 0;
  bit prev_stall = 0;
  logic [BEAT_W+SW-1:0] stall_pl;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int i, input int len, input int gap_at, input int gap_len, input bit rnd_gap);
    src_beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data        = $urandom;
      b.data[31:28] = 4'(i);
      b.keep        = 4'($urandom_range(1, 15));
      b.strb        = b.keep & 4'($urandom);
      b.last        = (k == len - 1);
      b.user        = UW'($urandom);
      b.gap         = rnd_gap ? 4'($urandom_range(0, 2)) : ((k == gap_at) ? 4'(gap_len) : 4'd0);
      src_q[i].push_back(b);
      exp_q[i].push_back({b.data, b.strb, b.keep, b.last, b.user});
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      presenting[i] = 0;
      gap_used[i]   = 0;
      fired[i]      = 0;
    end
  endtask

  task automatic clear_log();
    pkt_tid_q.delete();
    out_cyc_q.delete();
    out_last_q.delete();
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk); #1;
      busy = m_tvalid;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1;
      n++;
    end while (busy && n < max_cyc);
    check({name, "_drained"}, 64'(busy), 64'(0));
    if (busy) flush_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_order(input string name, input logic [47:0] ord, input int n);
    check({name, "_npkt"}, 64'(pkt_tid_q.size()), 64'(n));
    for (int k = 0; k < n && k < pkt_tid_q.size(); k++)
      check({name, "_tid"}, 64'(pkt_tid_q[k]), 64'(ord[47-4*k -: 4]));
  endtask

  // Source side: after each edge, retire transferred beats and offer the next one.
  initial begin
    src_beat_t hb;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0; s_tuser = '0;
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          presenting[i] = 0;
          gap_used[i]   = 0;
        end
        if (!presenting[i] && src_q[i].size() > 0) begin
          hb = src_q[i][0];
          if (gap_used[i] >= int'(hb.gap)) presenting[i] = 1;
          else gap_used[i]++;
        end
        if (presenting[i] && src_q[i].size() > 0) begin
          hb = src_q[i][0];
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = hb.last;
          s_tdata[i*DW +: DW] = hb.data;
          s_tstrb[i*BW +: BW] = hb.strb;
          s_tkeep[i*BW +: BW] = hb.keep;
          s_tuser[i*UW +: UW] = hb.user;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_tdata[i*DW +: DW] = '0;
          s_tstrb[i*BW +: BW] = '0;
          s_tkeep[i*BW +: BW] = '0;
          s_tuser[i*UW +: UW] = '0;
        end
      end
      m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int tid;
    logic [BEAT_W-1:0] got;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        fired[i] = s_tvalid[i] && s_tready[i] && !reset;
        if (fired[i]) fire_cnt[i]++;
      end
      if ($countones(s_tready) > 1) onehot_err++;
      if (t3_watch) begin
        if (s_tready[1] && !t3_done) early_err++;
        if (fired[2] && s_tlast[2]) t3_done = 1;
      end
      if (reset) begin
        in_pkt     = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall && (!m_tvalid || {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tuser, m_tid} !== stall_pl))
          stab_err++;
        prev_stall = m_tvalid && !m_tready;
        stall_pl   = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tuser, m_tid};
        if (m_tvalid && m_tready) begin
          tid = int'(m_tid);
          got = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tuser};
          out_cyc_q.push_back(cyc);
          out_last_q.push_back(m_tlast);
          beats_seen++;
          if (in_pkt) check("pkt_contiguous_tid", 64'(tid), 64'(cur_tid));
          else begin
            pkt_tid_q.push_back(tid);
            cur_tid = tid;
            in_pkt  = 1;
          end
          check("beat_expected", 64'(exp_q[tid].size() > 0), 64'(1));
          if (exp_q[tid].size() > 0) check("beat_payload", 64'(got), 64'(exp_q[tid].pop_front()));
          if (m_tlast) in_pkt = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    row_t rows[7];
    int   n;
    int   base;
    int   beats_total;
    int   spc;

    rows[0] = '{4'hf, 3, 1, 4,  48'h0123_0000_0000};
    rows[1] = '{4'h6, 2, 1, 2,  48'h1200_0000_0000};
    rows[2] = '{4'hb, 1, 1, 3,  48'h3010_0000_0000};
    rows[3] = '{4'h5, 4, 1, 2,  48'h2000_0000_0000};
    rows[4] = '{4'h1, 1, 1, 1,  48'h0000_0000_0000};
    rows[5] = '{4'h9, 2, 1, 2,  48'h3000_0000_0000};
    rows[6] = '{4'hf, 1, 3, 12, 48'h1230_1230_1230};

    for (int i = 0; i < N; i++) begin fire_cnt[i] = 0; presenting[i] = 0; gap_used[i] = 0; fired[i] = 0; end

    // 1: reset with every input requesting
    for (int i = 0; i < N; i++) load_pkt(i, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata",  64'(m_tdata),  64'(0));
    check("rst_m_tid",    64'(m_tid),    64'(0));
    check("rst_m_tlast",  64'(m_tlast),  64'(0));
    check("rst_m_tkeep",  64'({m_tkeep, m_tstrb, m_tuser}), 64'(0));
    clear_log();
    @(negedge clk); reset = 1'b0;
    wait_drain("reset_release", 200);
    check_order("reset_release", 48'h0123_0000_0000, 4);

    // 2 and 5: table-driven simultaneous-request scenarios, m_tready held high
    for (int r = 0; r < 7; r++) begin
      clear_log();
      for (int p = 0; p < rows[r].npk; p++)
        for (int i = 0; i < N; i++)
          if (((rows[r].mask >> i) & 1) != 0) load_pkt(i, rows[r].len, -1, 0, 0);
      wait_drain($sformatf("row%0d", r), 400);
      check_order($sformatf("row%0d", r), rows[r].ord, rows[r].n_ord);
      // beats of one packet are back to back; one idle cycle between packets
      for (int k = 1; k < out_cyc_q.size(); k++) begin
        spc = out_last_q[k-1] ? 2 : 1;
        check($sformatf("row%0d_spacing", r), 64'(out_cyc_q[k] - out_cyc_q[k-1]), 64'(spc));
      end
    end

    // 3: grant held across a 4-cycle source gap while input 1 waits
    clear_log();
    early_err = 0; t3_done = 0; t3_watch = 1;
    base = fire_cnt[2];
    load_pkt(2, 4, 2, 4, 0);
    n = 0;
    while (fire_cnt[2] == base && n < 50) begin @(negedge clk); #1; n++; end
    check("gap_first_beat", 64'(fire_cnt[2] > base), 64'(1));
    load_pkt(1, 2, -1, 0, 0);
    wait_drain("gap", 200);
    t3_watch = 0;
    check_order("gap", 48'h2100_0000_0000, 2);
    check("gap_no_early_ready", 64'(early_err), 64'(0));
    check("gap_tlast_seen", 64'(t3_done), 64'(1));

    // 4: random traffic with a 50% output ready
    clear_log();
    ready_pct = 50;
    beats_seen = 0;
    beats_total = 0;
    for (int p = 0; p < 200; p++) begin
      n = $urandom_range(1, 5);
      load_pkt($urandom_range(0, N-1), n, -1, 0, 1);
      beats_total += n;
    end
    wait_drain("random", 20000);
    check("random_beats", 64'(beats_seen), 64'(beats_total));
    check("random_packets", 64'(pkt_tid_q.size()), 64'(200));
    check("random_stall_stable", 64'(stab_err), 64'(0));

    // 6: reset during beat 2 of a 5-beat packet
    ready_pct = 100;
    load_pkt(0, 1, -1, 0, 0);
    wait_drain("pre_reset", 100);
    clear_log();
    base = fire_cnt[2];
    load_pkt(2, 5, -1, 0, 0);
    n = 0;
    while (fire_cnt[2] == base && n < 50) begin @(negedge clk); #1; n++; end
    check("midpkt_beat1", 64'(fire_cnt[2] - base), 64'(1));
    @(posedge clk); #2;
    check("midpkt_out_busy", 64'(m_tvalid), 64'(1));
    reset = 1'b1;
    #1;
    check("midpkt_m_tvalid", 64'(m_tvalid), 64'(0));
    check("midpkt_s_tready", 64'(s_tready), 64'(0));
    check("midpkt_m_tdata",  64'(m_tdata),  64'(0));
    flush_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    load_pkt(1, 1, -1, 0, 0);
    load_pkt(0, 1, -1, 0, 0);
    wait_drain("after_reset", 100);
    check_order("after_reset", 48'h0100_0000_0000, 2);

    check("ready_onehot", 64'(onehot_err), 64'(0));
    check("stall_stable", 64'(stab_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
